// File: rtl/hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller
//
// Central stall/flush sequencer for the 5-stage MIPS pipeline. It works
// alongside the EXE-stage forwarding unit. It handles four cases:
//   - Load-use hazards, and RAW hazards when forwarding is off, detected in ID:
//     it holds PC and IF/ID and injects a bubble into ID/EXE.
//   - Taken branches resolved in EXE: it flushes IF/ID and bubbles ID/EXE to
//     squash the wrong-path instructions.
//   - Data-memory wait: it freezes every pipeline register until mem_ready.
//   - Memory timeout: it enters a sticky ERROR state. Only rst leaves it.
//
// Configuration macro:
//   FORWARDING_EN - when defined, the forwarding unit resolves every non-load
//                   RAW hazard, so only load-use stalls. When undefined, any
//                   EXE or MEM writer that matches an ID source stalls.
//
// Parameters:
//   MEM_TIMEOUT - maximum consecutive memory-wait cycles (1..255).
//   CNT_W       - width of the saturating stall-cycle counter.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   src1_ID, src2_ID, two_src_ID   ID-stage source registers
//   dest_EXE, WB_EN_EXE, MEM_R_EN_EXE   EXE-stage writer info
//   dest_MEM, WB_EN_MEM            MEM-stage writer info
//   br_taken_EXE                   branch/jump resolved taken in EXE
//   mem_req_MEM, mem_ready         data-memory handshake
//   freeze_PC, freeze_IF_ID        hold PC / IF-ID register
//   bubble_ID_EXE, flush_IF_ID     load NOP into ID/EXE, clear IF/ID
//   freeze_all                     hold every pipeline register
//   mem_timeout                    sticky memory-timeout error flag
//   stall_cnt                      saturating count of stalled/frozen cycles
// ---------------------------------------------------------------------------
module hazard_stall_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       src1_ID,
  input  logic [4:0]       src2_ID,
  input  logic             two_src_ID,
  input  logic [4:0]       dest_EXE,
  input  logic             WB_EN_EXE,
  input  logic             MEM_R_EN_EXE,
  input  logic [4:0]       dest_MEM,
  input  logic             WB_EN_MEM,
  input  logic             br_taken_EXE,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  output logic             freeze_PC,
  output logic             freeze_IF_ID,
  output logic             bubble_ID_EXE,
  output logic             flush_IF_ID,
  output logic             freeze_all,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

  state_t           state_reg, state_next;
  logic [7:0]       wait_cnt_reg, wait_cnt_next;
  logic             mem_timeout_reg, mem_timeout_next;
  logic [CNT_W-1:0] stall_cnt_reg;

  // -------------------------------------------------------------------------
  // Hazard detection. Register 0 never matches. src2 is only a real operand
  // when two_src_ID is set.
  // -------------------------------------------------------------------------
  logic hit_exe;
  logic hit_mem;
  logic load_use_hit;
  logic data_stall;

  assign hit_exe = WB_EN_EXE && (dest_EXE != 5'd0) &&
                   ((src1_ID == dest_EXE) || (two_src_ID && (src2_ID == dest_EXE)));
  assign hit_mem = WB_EN_MEM && (dest_MEM != 5'd0) &&
                   ((src1_ID == dest_MEM) || (two_src_ID && (src2_ID == dest_MEM)));
  assign load_use_hit = hit_exe && MEM_R_EN_EXE;

`ifdef FORWARDING_EN
  // Forwarding covers every ALU result, so only a load that is still in EXE
  // cannot be forwarded in time.
  assign data_stall = load_use_hit;
`else
  // No forwarding: any in-flight writer that matches must drain to WB first.
  // The load-use case is a subset of hit_exe. It is kept here for clarity.
  assign data_stall = load_use_hit || hit_exe || hit_mem;
`endif

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    mem_timeout_next = mem_timeout_reg;
    freeze_PC        = 1'b0;
    freeze_IF_ID     = 1'b0;
    bubble_ID_EXE    = 1'b0;
    flush_IF_ID      = 1'b0;
    freeze_all       = 1'b0;

    case (state_reg)
      RUN: begin
        if (mem_req_MEM && !mem_ready) begin
          freeze_all    = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd1;
        end else if (br_taken_EXE) begin
          // The ID instruction is on the wrong path, so any hazard it has
          // is irrelevant. Squash both the IF/ID and ID/EXE slots.
          flush_IF_ID   = 1'b1;
          bubble_ID_EXE = 1'b1;
        end else if (data_stall) begin
          freeze_PC     = 1'b1;
          freeze_IF_ID  = 1'b1;
          bubble_ID_EXE = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (mem_req_MEM && mem_ready) begin
          // The pipeline moves again this cycle, so branch and hazard rules
          // apply exactly as they do in RUN.
          state_next    = RUN;
          wait_cnt_next = 8'd0;
          if (br_taken_EXE) begin
            flush_IF_ID   = 1'b1;
            bubble_ID_EXE = 1'b1;
          end else if (data_stall) begin
            freeze_PC     = 1'b1;
            freeze_IF_ID  = 1'b1;
            bubble_ID_EXE = 1'b1;
          end
        end else begin
          freeze_all = 1'b1;
          if (wait_cnt_reg >= TIMEOUT_LIMIT) begin
            state_next       = ERROR;
            mem_timeout_next = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
          end
        end
      end

      ERROR: begin
        freeze_all = 1'b1;
      end

      default: begin
        state_next = RUN;
      end
    endcase

    // Reset forces every control output low, whatever the other inputs are.
    if (rst) begin
      freeze_PC     = 1'b0;
      freeze_IF_ID  = 1'b0;
      bubble_ID_EXE = 1'b0;
      flush_IF_ID   = 1'b0;
      freeze_all    = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic stall_cycle;
  // A flush alone does not count as a stall.
  assign stall_cycle = freeze_PC || freeze_all || bubble_ID_EXE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= 8'd0;
      mem_timeout_reg <= 1'b0;
      stall_cnt_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      mem_timeout_reg <= mem_timeout_next;
      if (stall_cycle && (stall_cnt_reg != {CNT_W{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end
  end

  assign mem_timeout = mem_timeout_reg;
  assign stall_cnt   = stall_cnt_reg;

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline; it pairs with the forwarding unit in EXE.
- Detects load-use and (forwarding off) RAW hazards in ID, squashes wrong-path instructions on taken branches, and freezes the whole pipeline while data memory is busy.
- Drives PC/IF-ID hold, ID/EXE bubble and flush controls, and keeps a stall-cycle performance counter plus a memory-timeout error flag.

Parameters:
- MEM_TIMEOUT, 16, max consecutive mem-wait cycles before error (range 1..255).
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- src1_ID  in  5  ID-stage source reg 1.
- src2_ID  in  5  ID-stage source reg 2.
- two_src_ID  in  1  ID instruction reads src2 as a register (R-type/store/branch).
- dest_EXE  in  5  EXE-stage destination.
- WB_EN_EXE  in  1  EXE instruction writes back.
- MEM_R_EN_EXE  in  1  EXE instruction is a load.
- dest_MEM  in  5  MEM-stage destination.
- WB_EN_MEM  in  1  MEM instruction writes back.
- br_taken_EXE  in  1  branch/jump resolved taken in EXE.
- mem_req_MEM  in  1  MEM-stage load/store access active.
- mem_ready  in  1  data memory completes access this cycle.
- freeze_PC  out  1  hold PC.
- freeze_IF_ID  out  1  hold IF/ID register.
- bubble_ID_EXE  out  1  load NOP into ID/EXE.
- flush_IF_ID  out  1  clear IF/ID to NOP.
- freeze_all  out  1  hold every pipeline register, including MEM/WB.
- mem_timeout  out  1  sticky error flag.
- stall_cnt  out  CNT_W  saturating count of stalled/frozen cycles.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. On reset: state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0.
- Reset-value outputs: all control outputs are 0 while rst=1, regardless of the other inputs.
- Output timing: control outputs are combinational from the current state and inputs, with zero latency. State, wait_cnt, mem_timeout and stall_cnt are registered.
- Register 0: a source equal to 0 never matches. src2_ID is ignored when two_src_ID=0.
- hit(d,en): en && d!=0 && (src1_ID==d || (two_src_ID && src2_ID==d)).
- States: RUN, MEM_WAIT, ERROR.
- RUN, priority order (highest first):
  1. mem_req_MEM && !mem_ready: freeze_all=1, all other outputs 0. Next state MEM_WAIT, wait_cnt=1.
  2. br_taken_EXE: flush_IF_ID=1 and bubble_ID_EXE=1 for one cycle. This overrides a load-use hit in the same cycle because the ID instruction is squashed.
  3. Load-use, hit(dest_EXE, WB_EN_EXE && MEM_R_EN_EXE): freeze_PC=1, freeze_IF_ID=1, bubble_ID_EXE=1. Lasts one cycle, since the next EXE is the bubble.
  4. Otherwise all outputs 0.
- MEM_WAIT:
  - freeze_all=1 every cycle until mem_ready=1.
  - On the mem_ready cycle: freeze_all=0, and RUN-priority rules 2-4 are evaluated that same cycle. Next state RUN, wait_cnt=0.
  - Else wait_cnt increments. When wait_cnt==MEM_TIMEOUT and mem_ready=0: next state ERROR, mem_timeout<=1.
  - br_taken_EXE and hazards are ignored while frozen.
- ERROR: freeze_all=1 and mem_timeout=1 permanently; only rst exits.
- stall_cnt: +1 on every cycle where any of freeze_PC, freeze_all or bubble_ID_EXE is 1. A flush alone does not count. Saturates at all-ones with no wrap.
- mem_ready while mem_req_MEM=0 is ignored.
- Reset mid-MEM_WAIT or in ERROR: return to RUN on the next edge; the counter and flag are cleared.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined: behaviour as above; the forwarding unit resolves all non-load RAW hazards.
- Undefined: rule 3 becomes hit(dest_EXE,WB_EN_EXE) || hit(dest_MEM,WB_EN_MEM), with any instruction type, not just loads. The stall repeats every cycle while the match holds, which is up to 2 cycles per dependency. Branch and memory priority are unchanged.

Test Plan:
- Load-use: EXE lw to dest=5 (WB_EN_EXE=1, MEM_R_EN_EXE=1), ID add with src1=5 -> freeze_PC=freeze_IF_ID=bubble_ID_EXE=1 for exactly 1 cycle; stall_cnt 0->1. Same case with dest=0 -> no stall.
- Branch vs load-use: br_taken_EXE=1 in the same cycle as a load-use hit -> flush_IF_ID=1, bubble_ID_EXE=1, freeze_PC=0; stall_cnt +1.
- Memory wait: mem_req_MEM=1, mem_ready low 3 cycles then high -> freeze_all=1 for 3 cycles, 0 on the ready cycle, state RUN; stall_cnt +3.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> ERROR is entered after the 4th wait cycle; mem_timeout=1 and freeze_all=1 stay asserted; rst for 1 cycle clears all outputs.
- FORWARDING_EN undefined: EXE add dest=7 WB_EN_EXE=1, ID src2=7 two_src_ID=1 -> stall cycle 1. Dependency then sits in MEM -> stall cycle 2, then released. With FORWARDING_EN defined -> no stall.
- Saturation: CNT_W=4, force 20 stall cycles -> stall_cnt holds 15.
